// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one C-bit carry chunk per stage, result valid STAGES cycles after accept.
// Backpressure: a full output stage with out_ready low freezes the whole pipe and drops in_ready.
`timescale 1ns/1ps
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C   = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // opa/opb carry the operands forward so upper chunks are added later;
  // res carries the lower result chunks already resolved.
  typedef struct packed {
    logic             vld;
    logic             cy;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
  } stage_t;

  stage_t     stg_q [STAGES];
  stage_t     stg_d [STAGES];
  stage_t     in_c;
  stage_t     src_c;
  logic [C:0] chunk_c;
  logic       stall;

  assign stall    = stg_q[STAGES-1].vld && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    in_c     = '0;
    in_c.vld = in_valid;
    in_c.cy  = sub ? ~cin : cin;
    in_c.opa = a;
    in_c.opb = sub ? ~b : b;
  end

  always_comb begin
    src_c   = '0;
    chunk_c = '0;
    for (int k = 0; k < STAGES; k++) begin
      src_c   = (k == 0) ? in_c : stg_q[(k == 0) ? 0 : k - 1];
      chunk_c = {1'b0, src_c.opa[k*C +: C]} + {1'b0, src_c.opb[k*C +: C]}
              + {{C{1'b0}}, src_c.cy};
      stg_d[k]               = src_c;
      stg_d[k].res[k*C +: C] = chunk_c[C-1:0];
      stg_d[k].cy            = chunk_c[C];
    end
  end

  // Bubbles only clear the valid bit; data registers load on real beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        if (stg_d[k].vld) begin
          stg_q[k] <= stg_d[k];
        end else begin
          stg_q[k].vld <= 1'b0;
        end
      end
    end
  end

  assign out_valid = stg_q[STAGES-1].vld;
  assign sum       = stg_q[STAGES-1].res;
  assign cout      = stg_q[STAGES-1].cy;
  assign ovf       = (stg_q[STAGES-1].opa[MSB] == stg_q[STAGES-1].opb[MSB]) &&
                     (stg_q[STAGES-1].res[MSB] != stg_q[STAGES-1].opa[MSB]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vector table, random streams and flow-control corners,
// all results checked through an in-order scoreboard.
`timescale 1ns/1ps
module tb_pipelined_addsub;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks       = 0;
  int failures     = 0;
  int cyc          = 0;
  int n_out        = 0;
  int stall_cycles = 0;
  bit tog_done     = 1'b0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    bit           lat;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vt[8];

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ts, input bit lat);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   full;
    exp_t         e;
    be     = ts ? ~tb_ : tb_;
    ce     = ts ? ~tc : tc;
    full   = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, ce};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ta[W-1] == be[W-1]) && (full[W-1] != ta[W-1]);
    e.lat  = lat;
    e.cyc  = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Presents one beat, holds it until accepted, returns one cycle later (#1 after the edge).
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                      input logic ts, input exp_t e);
    int guard = 0;
    bit done  = 1'b0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    cin      = tc;
    sub      = ts;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.cyc = cyc;
        if (!rst) sb.push_back(e);
        done = 1'b1;
      end else if (++guard > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    sub      = 1'($urandom);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((sb.size() != 0) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output-side monitor: scoreboard pops, latency and stall-hold checks.
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;
  bit           prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if ((out_valid !== 1'b1) || (sum !== prev_sum) || (cout !== prev_cout) || (ovf !== prev_ovf)) begin
          failures++;
          $display("FAIL stall_hold: got v=%b sum=%h cout=%b ovf=%b, required v=1 sum=%h cout=%b ovf=%b",
                   out_valid, sum, cout, ovf, prev_sum, prev_cout, prev_ovf);
        end
      end
      if (out_valid && !out_ready) begin
        stall_cycles++;
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready: got %b, required 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        exp_t e;
        n_out++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got sum=%h with no beat outstanding, required none", sum);
        end else begin
          e = sb.pop_front();
          if ((sum !== e.sum) || (cout !== e.cout) || (ovf !== e.ovf)) begin
            failures++;
            $display("FAIL result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, e.sum, e.cout, e.ovf);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.cyc != S) begin
              failures++;
              $display("FAIL latency: got %0d cycles, required %0d", cyc - e.cyc, S);
            end
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
      prev_ovf   = ovf;
    end
  end

  initial begin
    int snap;
    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    vt[5] = '{16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0};
    vt[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table, back-to-back with add/sub interleaved.
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.sum  = vt[i].sum;
      e.cout = vt[i].cout;
      e.ovf  = vt[i].ovf;
      e.lat  = 1'b1;
      e.cyc  = 0;
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, e);
    end
    drain(50);

    // Full-rate random stream.
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs, 1'b1));
    end
    drain(50);

    // Backpressure with a full pipe, released after several stalled cycles.
    stall_cycles = 0;
    out_ready    = 1'b0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      send(ra, rb, 1'(i), 1'(i >> 1), model(ra, rb, 1'(i), 1'(i >> 1), 1'b0));
    end
    drain(100);
    chk("stall_len_ge5", 32'(stall_cycles >= 5), 1);
    chk("bp_out_count", n_out, 114);

    // Random gaps on the input and random out_ready.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        tog_done  = 1'b1;
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs, 1'b0));
    end
    for (int n = 0; (n < 400) && !tog_done; n++) @(posedge clk);
    #1;
    chk("toggler_done", tog_done, 1);
    drain(50);
    chk("random_out_count", n_out, 154);

    // Reset with three beats in flight; a beat offered during reset is dropped.
    for (int i = 0; i < 3; i++) begin
      send(16'h0100 * 16'(i + 1), 16'h0011, 1'b0, 1'b0,
           model(16'h0100 * 16'(i + 1), 16'h0011, 1'b0, 1'b0, 1'b1));
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'h1111;
    b        = 16'h2222;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    snap = n_out;
    repeat (8) @(negedge clk);
    chk("rst_no_ghost", n_out, snap);
    @(posedge clk);
    #1;
    send(16'hABCD, 16'h1234, 1'b1, 1'b1, model(16'hABCD, 16'h1234, 1'b1, 1'b1, 1'b1));
    drain(50);
    chk("final_out_count", n_out, snap + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Computes A+B+cin or A−B−bin over WIDTH bits. The carry chain is split into STAGES chunks, with one chunk resolved per clock.
- Full throughput (one operation per cycle) with valid/ready flow control on both sides.
- Sits in the datapath wherever wide adds must close timing, e.g. accumulators and address generators.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages; WIDTH % STAGES == 0 required; chunk width C = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out; in sub mode 1 = no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 after reset.
- Arithmetic:
  - Effective B: b when sub=0, ~b when sub=1.
  - Effective carry-in: cin when sub=0, ~cin when sub=1.
  - Result: sum = (a + Beff + cineff) mod 2^WIDTH; cout = carry out of bit WIDTH−1.
  - ovf = (a[MSB] == Beff[MSB]) && (sum[MSB] != a[MSB]).
- Pipeline structure:
  - Stage k (0..STAGES−1) adds chunk k (bits kC..kC+C−1) of a and Beff plus the registered carry from stage k−1. Stage 0 uses cineff.
  - Not-yet-added upper chunks travel forward in skew registers; already-computed lower result chunks travel forward in de-skew registers.
  - Per-stage logic is at most a C-bit adder.
- Latency: a beat accepted at edge N (in_valid && in_ready) appears with out_valid=1 after edge N+STAGES−1, i.e. STAGES register stages. With STAGES=1 this is one register stage after the edge that accepts the beat.
- Handshake:
  - A beat transfers on input when in_valid && in_ready, and on output when out_valid && out_ready.
  - Stall condition: stall = out_valid && !out_ready.
  - in_ready = !stall, a purely combinational function of out_valid and out_ready.
  - During stall: every stage register, valid bit and output holds; no new beat is captured.
  - Without stall: the pipe advances every cycle; bubbles (valid=0) advance too, so empty stages compress.
- Boundary conditions:
  - Output must remain stable (sum, cout, ovf) while out_valid=1 and out_ready=0.
  - a, b, cin and sub are sampled only on an accepted beat; their values while in_valid=0 are ignored.
  - Reset asserted mid-operation discards all in-flight beats; out_valid is 0 the cycle after.
  - Reset and in_valid asserted in the same cycle: reset wins, the beat is dropped.
  - Wrap-around is modular; no saturation.
  - sub mode is latched per beat, so adds and subtracts may interleave back-to-back.

Test Plan:
- WIDTH=16, STAGES=4, add: a=0xFFFF, b=0x0001, cin=0 -> after 4 cycles out_valid=1, sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0, add -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract: sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then sub=1, a=0x0007, b=0x0005, cin=1 -> sum=0x0001, cout=1.
- Throughput: 100 back-to-back random beats with out_ready=1 -> 100 results in order, one per cycle starting at cycle 4, all matching the reference model.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with pipe full.
  - Required: in_ready=0 and sum, cout, ovf stable throughout.
  - On release: no beat lost or duplicated.
- Reset mid-flight: rst=1 for 1 cycle with 3 beats in flight -> out_valid=0 next cycle and none of the 3 results ever emerge; a new beat issued afterwards emerges 4 cycles later.
